// File: rtl/mp_job_sequencer.sv
// mp_job_sequencer: bus master that runs one operand/instruction job on the mp slave port
//   and returns the 64-bit result, or a timeout error, to the client.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   job_valid/job_ready              job handshake (ready only in IDLE)
//   job_opa, job_opb, job_instr      operands and two-halfword instruction
//   res_valid/res_ready              result handshake
//   res_data, res_err                result (zero on error) and timeout flag
//   busy                             high outside IDLE
//   s0_sel, s_wr, s_addr, s_din      registered mp bus drive
//   s_dout, interrupt_out            mp read data and completion level
module mp_job_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_opa,
   input  logic [31:0] job_opb,
   input  logic [31:0] job_instr,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        res_err,
   output logic        busy,
   output logic        s0_sel,
   output logic        s_wr,
   output logic [15:0] s_addr,
   output logic [31:0] s_din,
   input  logic [63:0] s_dout,
   input  logic        interrupt_out
);
   typedef enum logic [3:0] {
      IDLE, WR_A, WR_B, WR_I0, WR_I1, START, WAIT_INT, RD_RES, CAPTURE, CLR_INT, RESP
   } state_t;

   localparam logic [31:0] LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state, nxt;
   logic [31:0] opb_q, instr_q, cnt;
   logic [49:0] bus_nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     nxt = job_valid ? WR_A : IDLE;
         WR_A:     nxt = WR_B;
         WR_B:     nxt = WR_I0;
         WR_I0:    nxt = WR_I1;
         WR_I1:    nxt = START;
         START:    nxt = WAIT_INT;
         // interrupt has priority over a timeout landing in the same cycle
         WAIT_INT: nxt = interrupt_out ? RD_RES : (cnt == LAST) ? CLR_INT : WAIT_INT;
         RD_RES:   nxt = CAPTURE;
         CAPTURE:  nxt = CLR_INT;
         CLR_INT:  nxt = RESP;
         RESP:     nxt = res_ready ? IDLE : RESP;
         default:  nxt = IDLE;
      endcase
   end

   // Bus drive is derived from the next state so it is registered alongside it.
   // WR_A is only entered from the accepting cycle, so it takes job_opa live.
   always_comb begin
      bus_nxt = '0;
      case (nxt)
         WR_A:    bus_nxt = {2'b11, 16'h0101, job_opa};
         WR_B:    bus_nxt = {2'b11, 16'h0102, opb_q};
         WR_I0:   bus_nxt = {2'b11, 16'h0110, 16'h0, instr_q[15:0]};
         WR_I1:   bus_nxt = {2'b11, 16'h0111, 16'h0, instr_q[31:16]};
         START:   bus_nxt = {2'b11, 16'h0120, 32'h1};
         RD_RES:  bus_nxt = {2'b10, 16'h0130, 32'h0};
         CLR_INT: bus_nxt = {2'b11, 16'h0121, 32'h0};
         default: bus_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         {s0_sel, s_wr, s_addr, s_din} <= '0;
         job_ready <= 1'b1;
         busy <= 1'b0;
         res_valid <= 1'b0;
         res_data <= '0;
         res_err <= 1'b0;
         opb_q <= '0;
         instr_q <= '0;
         cnt <= '0;
      end else begin
         state <= nxt;
         {s0_sel, s_wr, s_addr, s_din} <= bus_nxt;
         job_ready <= nxt == IDLE;
         busy <= nxt != IDLE;
         res_valid <= nxt == RESP;
         // zero outside WAIT_INT, so every entry starts the count at 0
         cnt <= (state == WAIT_INT) ? cnt + 32'd1 : 32'd0;
         if (state == IDLE && job_valid) begin
            opb_q <= job_opb;
            instr_q <= job_instr;
            res_err <= 1'b0;
         end
         if (state == CAPTURE) res_data <= s_dout;
         if (state == WAIT_INT && nxt == CLR_INT) begin
            res_err <= 1'b1;
            res_data <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mp_job_sequencer.sv
// tb_mp_job_sequencer: directed bench for mp_job_sequencer with a small behavioural mp slave.
module tb_mp_job_sequencer;
   logic        clk = 0, reset_n = 0, job_valid = 0, res_ready = 0;
   logic [31:0] job_opa = 0, job_opb = 0, job_instr = 0;
   logic        job_ready, res_valid, res_err, busy, s0_sel, s_wr, interrupt_out;
   logic [63:0] res_data, s_dout;
   logic [15:0] s_addr;
   logic [31:0] s_din;

   typedef struct {int t; logic w; logic [15:0] a; logic [31:0] d;} op_t;
   op_t         ops[$];
   int          cyc = 0, cd = 0, dly = 0, checks = 0, errors = 0, lat = 0, n = 0;
   logic [63:0] mp_res = 0;

   always #5 clk = ~clk;

   mp_job_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
      .job_opa(job_opa), .job_opb(job_opb), .job_instr(job_instr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .busy(busy), .s0_sel(s0_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
      .s_dout(s_dout), .interrupt_out(interrupt_out)
   );

   // mp slave: logs bus ops, returns mp_res one cycle after a read, raises the
   // interrupt dly cycles after the start write (never when dly < 0)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset_n) begin
         interrupt_out <= 0;
         cd <= 0;
         s_dout <= 0;
      end else begin
         if (s0_sel) ops.push_back('{cyc, s_wr, s_addr, s_din});
         if (s0_sel && !s_wr) s_dout <= mp_res;
         if (s0_sel && s_wr && s_addr == 16'h0121) interrupt_out <= 0;
         if (s0_sel && s_wr && s_addr == 16'h0120 && dly >= 0) begin
            if (dly == 0) interrupt_out <= 1;
            else cd <= dly;
         end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1) interrupt_out <= 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk_op(input string tag, input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
      if (i >= ops.size()) chk({tag, " present"}, 64'(ops.size()), 64'(i + 1));
      else begin
         chk({tag, " wr"}, 64'(ops[i].w), 64'(w));
         chk({tag, " addr"}, 64'(ops[i].a), 64'(a));
         chk({tag, " data"}, 64'(ops[i].d), 64'(d));
      end
   endtask

   task automatic chk_dt(input string tag, input int i, input int j, input int exp);
      if (i >= ops.size()) chk({tag, " present"}, 64'(ops.size()), 64'(i + 1));
      else chk(tag, 64'(ops[i].t - ops[j].t), 64'(exp));
   endtask

   task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins,
                            input int d, input logic [63:0] r);
      @(negedge clk);
      ops.delete();
      dly = d;
      mp_res = r;
      job_opa = a;
      job_opb = b;
      job_instr = ins;
      job_valid = 1;
      chk("job_ready idle", 64'(job_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 0;
      chk("busy accepted", 64'(busy), 64'd1);
      chk("res_err cleared", 64'(res_err), 64'd0);
   endtask

   // lat = edges from the job handshake to the first edge that sees res_valid
   task automatic wait_res(output int l);
      int k = 0;
      while (!res_valid && k < 200) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      chk("res_valid", 64'(res_valid), 64'd1);
      l = k + 1;
   endtask

   task automatic take_res;
      @(negedge clk);
      res_ready = 1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 0;
      job_valid = 0;
      chk("res_valid drop", 64'(res_valid), 64'd0);
      chk("job_ready back", 64'(job_ready), 64'd1);
      chk("busy drop", 64'(busy), 64'd0);
   endtask

   task automatic chk_prog(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins);
      chk_op("wr_a", 0, 1, 16'h0101, a);
      chk_op("wr_b", 1, 1, 16'h0102, b);
      chk_op("wr_i0", 2, 1, 16'h0110, {16'h0, ins[15:0]});
      chk_op("wr_i1", 3, 1, 16'h0111, {16'h0, ins[31:16]});
      chk_op("start", 4, 1, 16'h0120, 32'h1);
      chk_dt("prog spacing", 4, 0, 4);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst job_ready", 64'(job_ready), 64'd1);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst res_valid", 64'(res_valid), 64'd0);
      chk("rst res_data", res_data, 64'd0);
      chk("rst res_err", 64'(res_err), 64'd0);
      chk("rst bus", {s0_sel, s_wr, s_addr, s_din}, 64'd0);
      reset_n = 1;

      // single job, fastest interrupt: minimum latency
      start_job(32'd7, 32'hFFFF_FFF9, 32'h7336_1312, 0, 64'h1234_5678_9ABC_DEF0);
      wait_res(lat);
      chk("t1 latency", 64'(lat), 64'd10);
      chk("t1 res_data", res_data, 64'h1234_5678_9ABC_DEF0);
      chk("t1 res_err", 64'(res_err), 64'd0);
      chk("t1 job_ready", 64'(job_ready), 64'd0);
      chk_prog(32'd7, 32'hFFFF_FFF9, 32'h7336_1312);
      chk_op("t1 read", 5, 0, 16'h0130, 32'h0);
      chk_op("t1 clr", 6, 1, 16'h0121, 32'h0);
      chk_dt("t1 read gap", 5, 4, 2);
      chk_dt("t1 clr gap", 6, 5, 2);
      chk("t1 op count", 64'(ops.size()), 64'd7);
      take_res();

      // MUL 7 * -7, interrupt sampled at edge 9
      start_job(32'd7, 32'hFFFF_FFF9, 32'h0000_8312, 3, 64'hFFFF_FFFF_FFFF_FFCF);
      wait_res(lat);
      chk("t2 latency", 64'(lat), 64'd13);
      chk("t2 res_data", res_data, 64'hFFFF_FFFF_FFFF_FFCF);
      chk_prog(32'd7, 32'hFFFF_FFF9, 32'h0000_8312);
      chk_op("t2 read", 5, 0, 16'h0130, 32'h0);
      chk_op("t2 clr", 6, 1, 16'h0121, 32'h0);
      chk_dt("t2 read gap", 5, 4, 5);
      chk_dt("t2 clr gap", 6, 5, 2);
      take_res();

      // timeout: 16 wait cycles plus the clear cycle after the start write
      start_job(32'h1, 32'h2, 32'h0003_0004, -1, 64'hDEAD_DEAD_DEAD_DEAD);
      wait_res(lat);
      chk("t3 latency", 64'(lat), 64'd23);
      chk("t3 res_err", 64'(res_err), 64'd1);
      chk("t3 res_data", res_data, 64'd0);
      chk("t3 op count", 64'(ops.size()), 64'd6);
      chk_op("t3 clr", 5, 1, 16'h0121, 32'h0);
      chk_dt("t3 clr gap", 5, 4, 17);
      take_res();

      // backpressure with a pending job; res_err from the timeout must clear
      start_job(32'h10, 32'h20, 32'h0030_0040, 1, 64'h0BAD_CAFE_0000_0042);
      wait_res(lat);
      chk("t4 latency", 64'(lat), 64'd11);
      job_opa = 32'h55;
      job_opb = 32'h66;
      job_instr = 32'h0077_8312;
      job_valid = 1;
      n = ops.size();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp res_valid", 64'(res_valid), 64'd1);
         chk("bp res_data", res_data, 64'h0BAD_CAFE_0000_0042);
         chk("bp res_err", 64'(res_err), 64'd0);
         chk("bp job_ready", 64'(job_ready), 64'd0);
         chk("bp s0_sel", 64'(s0_sel), 64'd0);
      end
      chk("bp bus quiet", 64'(ops.size()), 64'(n));
      take_res();
      start_job(32'h55, 32'h66, 32'h0077_8312, 0, 64'h5555);
      wait_res(lat);
      chk("t4b latency", 64'(lat), 64'd10);
      chk("t4b res_data", res_data, 64'h5555);
      chk_prog(32'h55, 32'h66, 32'h0077_8312);
      take_res();

      // reset asserted during WR_I0
      start_job(32'h1, 32'h2, 32'h3, 0, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre-rst addr", 64'(s_addr), 64'h0110);
      chk("pre-rst sel", 64'(s0_sel), 64'd1);
      reset_n = 0;
      #1;
      chk("mid-rst s0_sel", 64'(s0_sel), 64'd0);
      chk("mid-rst busy", 64'(busy), 64'd0);
      chk("mid-rst res_valid", 64'(res_valid), 64'd0);
      chk("mid-rst job_ready", 64'(job_ready), 64'd1);
      @(negedge clk);
      reset_n = 1;
      start_job(32'hA, 32'hB, 32'h0000_8312, 2, 64'h77);
      wait_res(lat);
      chk("t5 latency", 64'(lat), 64'd12);
      chk("t5 res_data", res_data, 64'h77);
      chk_prog(32'hA, 32'hB, 32'h0000_8312);
      take_res();

      // interrupt arrives on the last timeout cycle: interrupt wins
      start_job(32'h3, 32'h4, 32'h0000_1312, 15, 64'hC0FF_EE00_1234_0001);
      wait_res(lat);
      chk("t6 latency", 64'(lat), 64'd25);
      chk("t6 res_err", 64'(res_err), 64'd0);
      chk("t6 res_data", res_data, 64'hC0FF_EE00_1234_0001);
      chk_op("t6 read", 5, 0, 16'h0130, 32'h0);
      chk_dt("t6 read gap", 5, 4, 17);
      take_res();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mp_job_sequencer.md
# mp_job_sequencer

Bus master that drives the `mp` slave port on behalf of a client. It accepts one job per handshake: two 32-bit operands plus one two-halfword instruction. For each job it writes the operands and instruction into `mp`, issues start, waits for `interrupt_out`, reads back the 64-bit result, clears the interrupt, and returns the result (or a timeout error) on a second handshake. It replaces hand-sequenced bus writes in system benches and sits between the client logic and `mp`'s `s_*` port.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles spent in WAIT_INT before the job is aborted with an error.
- `clk` input 1: single clock. All logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `job_valid` input 1: a job is presented.
- `job_ready` output 1: high only in IDLE. The job transfers when `job_valid & job_ready`.
- `job_opa` input 32: operand A, written to `mp` data[1].
- `job_opb` input 32: operand B, written to `mp` data[2].
- `job_instr` input 32: instruction word. `[15:0]` is the first halfword and `[31:16]` is the second.
- `res_valid` output 1: result held valid until `res_ready`.
- `res_ready` input 1: client accepts the result.
- `res_data` output 64: result captured from `s_dout`. Forced to 0 on error.
- `res_err` output 1: the job timed out. Qualified by `res_valid`.
- `busy` output 1: high in every state except IDLE.
- `s0_sel` output 1: `mp` select.
- `s_wr` output 1: 1 = write, 0 = read.
- `s_addr` output 16: `mp` address.
- `s_din` output 32: write data.
- `s_dout` input 64: `mp` read data, registered by `mp`, valid the cycle after the read address.
- `interrupt_out` input 1: `mp` completion, level, held until cleared.

## Operation
- `mp` address map:
  - 0x0101: operand A.
  - 0x0102: operand B.
  - 0x0110: instruction low halfword.
  - 0x0111: instruction high halfword.
  - 0x0120: start; write 1.
  - 0x0121: interrupt clear; write 0.
  - 0x0130: result read.
- Accepting a job registers `job_opa`, `job_opb` and `job_instr` internally. Inputs are ignored outside IDLE.
- FSM states and their bus drive:
  - IDLE: bus idle.
  - WR_A: write 0x0101 ← opa.
  - WR_B: write 0x0102 ← opb.
  - WR_I0: write 0x0110 ← {16'h0, instr[15:0]}.
  - WR_I1: write 0x0111 ← {16'h0, instr[31:16]}.
  - START: write 0x0120 ← 1.
  - WAIT_INT: bus idle. The timeout counter runs.
  - RD_RES: `s0_sel=1`, `s_wr=0`, address 0x0130.
  - CAPTURE: bus idle. `res_data ← s_dout`.
  - CLR_INT: write 0x0121 ← 0.
  - RESP: `res_valid=1`.
- Transitions:
  - IDLE→WR_A on handshake.
  - WR_A→WR_B→WR_I0→WR_I1→START→WAIT_INT unconditionally, one cycle each.
  - WAIT_INT→RD_RES when `interrupt_out` is sampled 1.
  - WAIT_INT→CLR_INT on timeout, with `res_err←1` and `res_data←0`.
  - RD_RES→CAPTURE→CLR_INT→RESP.
  - RESP→IDLE when `res_ready` is high.
- Bus idle means `s0_sel=0`, `s_wr=0`, `s_addr=16'h0000`, `s_din=32'h0`. All bus outputs are registered.
- The timeout counter clears on entry to WAIT_INT and increments each cycle in WAIT_INT. Timeout fires when the count reaches `TIMEOUT_CYCLES-1` with `interrupt_out` still low.
- If interrupt and timeout coincide in the same cycle, the interrupt wins and the job completes normally.
- `res_err` clears on the next job acceptance.
- No back-to-back bypass: a new job is accepted no earlier than the cycle after the RESP handshake.

## Timing
- Reset values of outputs: all 0, including `res_data`. `job_ready` is 1 after reset (IDLE).
- Asserting `reset_n` mid-job immediately returns the FSM to IDLE and idles the bus. A partially programmed `mp` is not cleaned up.
- The handshake occurs at edge 0. WR_A bus values are visible from edge 1, and START from edge 5.
- The earliest `interrupt_out` sample is the first cycle of WAIT_INT, edge 6.
- If the interrupt is sampled at edge k, then RD_RES is at k+1, CAPTURE at k+2, CLR_INT at k+3, and `res_valid` rises at k+4.
- Minimum job→result latency is 10 cycles.
- `res_valid`, `res_data` and `res_err` are stable while `res_ready` is low.

## Test plan
- Single job, `mp` NOT then done:
  - Stimulus: opa=7, opb=0xFFFF_FFF9, instr={16'h7336, 16'h1312}.
  - Required: bus shows the 5 writes in order at 0x0101, 0x0102, 0x0110, 0x0111, 0x0120 with the exact data.
  - Required: `res_data` equals `mp` s_dout and `res_err`=0.
- MUL job 7 × −7:
  - Stimulus: instr low halfword 0x8312.
  - Required: `res_data`=64'hFFFF_FFFF_FFFF_FFCF.
  - Required: CLR_INT write of 0 to 0x0121 follows the result read.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16, `interrupt_out` held 0.
  - Required: CLR_INT occurs exactly 16 cycles after WAIT_INT entry, then `res_valid`=1, `res_err`=1, `res_data`=0.
- Result backpressure:
  - Stimulus: hold `res_ready`=0 for 20 cycles, and present `job_valid` meanwhile.
  - Required: outputs are stable, `job_ready`=0, no bus activity; the next job is accepted only after the RESP handshake.
- Reset mid-job:
  - Stimulus: drop `reset_n` during WR_I0.
  - Required: within the same cycle `s0_sel`=0, `busy`=0, `res_valid`=0.
  - Required: after release, a fresh job runs normally.
- Interrupt/timeout collision:
  - Stimulus: `interrupt_out` rises on the final timeout cycle.
  - Required: normal completion with `res_err`=0.
